i2c_cfg_arbiter: RTL and testbench
==================================

Name: i2c_cfg_arbiter

Overview:
- Shares one i2c_com write engine between two camera register-configuration sequencers (left = requester 0, right = requester 1) in the binocular capture path.
- Each requester presents a 32-bit {device address, 16-bit register, 8-bit value} word with a level start and holds it until done.
- The arbiter grants round-robin, forwards the word to the engine, and routes completion and ack back to the winner.
- It enforces an inter-transfer bus-idle gap and a watchdog timeout so a hung transfer cannot stall both cameras.

Parameters:
DATA_W, 32, width of one I2C write word ({dev_addr, reg_addr, reg_val})
GAP_CYCLES, 4, clock_i2c cycles of enforced idle between consecutive transfers (min 1)
TIMEOUT_CYCLES, 200, max clock_i2c cycles in BUSY before the transfer is force-terminated
CNT_W, 8, counter width; must hold max(GAP_CYCLES, TIMEOUT_CYCLES)

Ports:
clock_i2c  in  1  I2C bit-rate clock (20 kHz domain); all logic on rising edge
camera_rst  in  1  reset, asynchronous, active-high
req0_start  in  1  requester 0 level request; held with req0_data until req0_done
req0_data  in  DATA_W  requester 0 write word
req0_done  out  1  requester 0 transfer finished; held until req0_start drops
req0_ack  out  1  engine ack captured at completion (valid while req0_done)
req0_timeout  out  1  completion was forced by watchdog (valid while req0_done)
req1_start, req1_data, req1_done, req1_ack, req1_timeout  same as above, for requester 1
i2c_data  out  DATA_W  word to i2c_com
start  out  1  start to i2c_com; held high for the whole transfer
tr_end  in  1  i2c_com transfer-complete
ack  in  1  i2c_com ack status
grant  out  2  one-hot owner; 2'b00 when idle
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high):
  - all outputs 0; i2c_data = 0; state IDLE; counters 0.
  - last_grant = 1, so requester 0 wins the first tie.
- States: IDLE, BUSY, DONE, GAP.
- IDLE:
  - If exactly one reqN_start is high, grant it.
  - If both are high, grant the one not equal to last_grant.
  - On grant (registered, 1-cycle latency):
    - i2c_data <= winner data; start <= 1; grant <= onehot(winner); last_grant <= winner.
    - Clear timeout counter; go to BUSY.
- BUSY:
  - i2c_data is frozen; later requester data changes are ignored.
  - Timeout counter increments each cycle.
  - If tr_end = 1: start <= 0; winner done <= 1; winner ack <= ack; winner timeout <= 0; go to DONE.
  - Else if the counter reaches TIMEOUT_CYCLES-1: start <= 0; done <= 1; ack <= 0; timeout <= 1; go to DONE.
  - tr_end takes priority over timeout when both occur in the same cycle.
- DONE:
  - done, ack and timeout hold stable.
  - When the winner's start = 0: clear done, ack and timeout; grant <= 0; load gap counter; go to GAP.
  - If the requester dropped start during BUSY (abort), the engine transfer still completes, and done is a single-cycle pulse.
- GAP:
  - Count GAP_CYCLES cycles with start = 0, then go to IDLE.
  - Requests raised during GAP are not lost; they are arbitrated in IDLE.
- Fairness:
  - With both requesters continuously requesting, grants strictly alternate 0,1,0,1.
  - A lone requester may be granted back-to-back, each separated by the gap.
- The non-granted requester's done, ack and timeout stay 0 at all times.
- Reset mid-transfer: start drops asynchronously; the i2c_com engine is reset by the same camera_rst.

Decomposition:
- Shared package i2c_cfg_pkg:
  - state encoding constants (IDLE = 0, BUSY = 1, DONE = 2, GAP = 3)
  - DATA_W
  - OV5640 device address constant 8'h78
  - word field positions (dev [31:24], reg [23:8], val [7:0])
- Optional sub-module rr_arb2: 2-way round-robin picker (req[1:0], last -> winner, valid), combinational.
- Counters and FSM live in the top module.

Test Plan:
- Reset then req0_start = 1, req0_data = 32'h78310311 -> one cycle later start = 1, i2c_data = 32'h78310311, grant = 01. Drive tr_end = 1 with ack = 1 after 40 cycles -> req0_done = 1, req0_ack = 1. Drop req0_start -> done = 0, then start stays 0 for exactly 4 cycles.
- req0 and req1 both raised in the same cycle after reset, held continuously -> grant sequence 01, 10, 01, 10 across 4 transfers; each i2c_data matches the owner's word.
- Engine never asserts tr_end -> start drops after exactly 200 BUSY cycles; req1_done = 1, req1_timeout = 1, req1_ack = 0.
- req0 drops start mid-BUSY, then tr_end pulses -> req0_done is a single-cycle pulse; GAP of 4 cycles follows; a pending req1 is granted next.
- tr_end asserts on the same cycle the timeout expires -> timeout = 0; ack equals the engine ack value.
- Assert camera_rst during BUSY -> start, grant, busy and all done flags go to 0 immediately (before the next clock edge). After release, requester 0 wins the first tie.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the camera I2C configuration arbiter: FSM state
// encoding, word layout of one register write and small helpers.
package i2c_cfg_pkg;

    localparam int DATA_W = 32;

    // OV5640 8-bit write address
    localparam logic [7:0] OV5640_DEV_ADDR = 8'h78;

    // Field positions inside one configuration word
    localparam int DEV_MSB = 31;
    localparam int DEV_LSB = 24;
    localparam int REG_MSB = 23;
    localparam int REG_LSB = 8;
    localparam int VAL_MSB = 7;
    localparam int VAL_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

    // One-hot owner code for a requester index
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Builds an OV5640 register write word
    function automatic logic [31:0] cfg_word(input logic [15:0] reg_addr,
                                             input logic [7:0]  reg_val);
        logic [31:0] w;
        w = '0;
        w[DEV_MSB:DEV_LSB] = OV5640_DEV_ADDR;
        w[REG_MSB:REG_LSB] = reg_addr;
        w[VAL_MSB:VAL_LSB] = reg_val;
        return w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // Winner selection for the current request pair
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/i2c_cfg_arbiter.sv
// Shares one i2c_com write engine between the left (0) and right (1) camera
// configuration sequencers, with round-robin grant, an idle gap between
// transfers and a watchdog that force-completes a hung transfer.
module i2c_cfg_arbiter #(
    parameter int DATA_W         = 32,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int CNT_W          = 8
) (
    input  logic              clock_i2c,
    input  logic              camera_rst,
    input  logic              req0_start,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_done,
    output logic              req0_ack,
    output logic              req0_timeout,
    input  logic              req1_start,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_done,
    output logic              req1_ack,
    output logic              req1_timeout,
    output logic [DATA_W-1:0] i2c_data,
    output logic              start,
    input  logic              tr_end,
    input  logic              ack,
    output logic [1:0]        grant,
    output logic              busy
);
    import i2c_cfg_pkg::*;

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              start_q, start_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        tmo_q, tmo_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic pick_winner;
    logic pick_valid;
    logic tmo_hit;
    logic owner_start;

    rr_arb2 u_rr (
        .req    ({req1_start, req0_start}),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // last_q doubles as the current owner once a grant has been issued
    assign tmo_hit     = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign owner_start = last_q ? req1_start : req0_start;

    // State and datapath registers; last_q resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clock_i2c or posedge camera_rst) begin
        if (camera_rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            start_q   <= 1'b0;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            done_q    <= 2'b00;
            ack_q     <= 2'b00;
            tmo_q     <= 2'b00;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            start_q   <= start_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            tmo_q     <= tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic; tr_end and the watchdog both end BUSY
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid)          state_d = ST_BUSY;
            ST_BUSY: if (tr_end || tmo_hit)   state_d = ST_DONE;
            ST_DONE: if (!owner_start)        state_d = ST_GAP;
            ST_GAP:  if (gap_cnt_q == '0)     state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Registered outputs and counters per state; tr_end outranks the watchdog
    always_comb begin
        data_d    = data_q;
        start_d   = start_q;
        grant_d   = grant_q;
        last_d    = last_q;
        done_d    = done_q;
        ack_d     = ack_q;
        tmo_d     = tmo_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    data_d    = pick_winner ? req1_data : req0_data;
                    start_d   = 1'b1;
                    grant_d   = onehot2(pick_winner);
                    last_d    = pick_winner;
                    tmo_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tr_end) begin
                    start_d = 1'b0;
                    done_d  = onehot2(last_q);
                    ack_d   = ack ? onehot2(last_q) : 2'b00;
                    tmo_d   = 2'b00;
                end else if (tmo_hit) begin
                    start_d = 1'b0;
                    done_d  = onehot2(last_q);
                    ack_d   = 2'b00;
                    tmo_d   = onehot2(last_q);
                end
            end
            ST_DONE: begin
                if (!owner_start) begin
                    done_d    = 2'b00;
                    ack_d     = 2'b00;
                    tmo_d     = 2'b00;
                    grant_d   = 2'b00;
                    gap_cnt_d = CNT_W'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    assign i2c_data     = data_q;
    assign start        = start_q;
    assign grant        = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign req0_done    = done_q[0];
    assign req1_done    = done_q[1];
    assign req0_ack     = ack_q[0];
    assign req1_ack     = ack_q[1];
    assign req0_timeout = tmo_q[0];
    assign req1_timeout = tmo_q[1];

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Directed bench for i2c_cfg_arbiter: a table of complete transfers plus
// hand-written sequences for timeout, abort, tr_end/timeout collision and
// reset during a transfer.
module tb_i2c_cfg_arbiter;
    import i2c_cfg_pkg::*;

    localparam int GAP = 4;
    localparam int TMO = 200;

    logic        clock_i2c = 1'b0;
    logic        camera_rst = 1'b1;
    logic        req0_start = 1'b0;
    logic [31:0] req0_data = '0;
    logic        req1_start = 1'b0;
    logic [31:0] req1_data = '0;
    logic        tr_end = 1'b0;
    logic        ack = 1'b0;
    logic        req0_done, req0_ack, req0_timeout;
    logic        req1_done, req1_ack, req1_timeout;
    logic [31:0] i2c_data;
    logic        start;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clock_i2c = ~clock_i2c;

    i2c_cfg_arbiter #(
        .DATA_W(32), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
    ) dut (
        .clock_i2c    (clock_i2c),
        .camera_rst   (camera_rst),
        .req0_start   (req0_start),
        .req0_data    (req0_data),
        .req0_done    (req0_done),
        .req0_ack     (req0_ack),
        .req0_timeout (req0_timeout),
        .req1_start   (req1_start),
        .req1_data    (req1_data),
        .req1_done    (req1_done),
        .req1_ack     (req1_ack),
        .req1_timeout (req1_timeout),
        .i2c_data     (i2c_data),
        .start        (start),
        .tr_end       (tr_end),
        .ack          (ack),
        .grant        (grant),
        .busy         (busy)
    );

    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] d0;
        logic [31:0] d1;
        int          lat;
        logic        eng_ack;
        logic [1:0]  exp_grant;
        logic [31:0] exp_data;
        logic        exp_ack;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clock_i2c);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("start_seen", {31'b0, start}, 32'd1);
    endtask

    task automatic gap_len();
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("gap_len", n, GAP);
    endtask

    task automatic close_xfer(input logic who);
        if (who) req1_start = 1'b0; else req0_start = 1'b0;
        tick();
        chk("done_clr", {30'b0, req1_done, req0_done}, 32'd0);
        chk("grant_clr", {30'b0, grant}, 32'd0);
        gap_len();
    endtask

    task automatic run_row(input vec_t v);
        req0_data  = v.d0;
        req1_data  = v.d1;
        req0_start = v.r0;
        req1_start = v.r1;
        wait_start();
        chk("grant", {30'b0, grant}, {30'b0, v.exp_grant});
        chk("i2c_data", i2c_data, v.exp_data);
        req0_data = ~v.d0;
        req1_data = ~v.d1;
        repeat (v.lat) tick();
        chk("start_held", {31'b0, start}, 32'd1);
        chk("data_frozen", i2c_data, v.exp_data);
        tr_end = 1'b1;
        ack    = v.eng_ack;
        tick();
        tr_end = 1'b0;
        ack    = 1'b0;
        chk("done", {30'b0, req1_done, req0_done}, {30'b0, v.exp_grant});
        chk("ack", {30'b0, req1_ack, req0_ack}, v.exp_ack ? {30'b0, v.exp_grant} : 32'd0);
        chk("timeout", {30'b0, req1_timeout, req0_timeout}, 32'd0);
        chk("start_low", {31'b0, start}, 32'd0);
        tick();
        chk("done_hold", {30'b0, req1_done, req0_done}, {30'b0, v.exp_grant});
        close_xfer(v.exp_grant[1]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{r0:1'b1, r1:1'b0, d0:32'h78310311, d1:32'h0, lat:40, eng_ack:1'b1,
                    exp_grant:2'b01, exp_data:32'h78310311, exp_ack:1'b1};
        vecs[1] = '{r0:1'b1, r1:1'b0, d0:32'h78300a11, d1:32'h0, lat:3, eng_ack:1'b0,
                    exp_grant:2'b01, exp_data:32'h78300a11, exp_ack:1'b0};
        vecs[2] = '{r0:1'b1, r1:1'b1, d0:32'h78300802, d1:32'h78420555, lat:5, eng_ack:1'b1,
                    exp_grant:2'b10, exp_data:32'h78420555, exp_ack:1'b1};
        vecs[3] = '{r0:1'b1, r1:1'b1, d0:32'h78310322, d1:32'h78310333, lat:2, eng_ack:1'b1,
                    exp_grant:2'b01, exp_data:32'h78310322, exp_ack:1'b1};
        vecs[4] = '{r0:1'b1, r1:1'b1, d0:32'h78380044, d1:32'h78380155, lat:7, eng_ack:1'b0,
                    exp_grant:2'b10, exp_data:32'h78380155, exp_ack:1'b0};
        vecs[5] = '{r0:1'b1, r1:1'b1, d0:32'h78381166, d1:32'h78381277, lat:1, eng_ack:1'b1,
                    exp_grant:2'b01, exp_data:32'h78381166, exp_ack:1'b1};
        vecs[6] = '{r0:1'b0, r1:1'b1, d0:32'h0, d1:32'h78500088, lat:4, eng_ack:1'b1,
                    exp_grant:2'b10, exp_data:32'h78500088, exp_ack:1'b1};
        vecs[7] = '{r0:1'b0, r1:1'b1, d0:32'h0, d1:32'h78500199, lat:6, eng_ack:1'b1,
                    exp_grant:2'b10, exp_data:32'h78500199, exp_ack:1'b1};

        // reset state
        tick();
        tick();
        chk("rst_start", {31'b0, start}, 32'd0);
        chk("rst_grant", {30'b0, grant}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_data", i2c_data, 32'd0);
        chk("rst_flags", {26'b0, req1_done, req1_ack, req1_timeout,
                          req0_done, req0_ack, req0_timeout}, 32'd0);
        camera_rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_row(vecs[i]);

        // watchdog: engine never answers
        req1_data  = cfg_word(16'h4200, 8'h11);
        req1_start = 1'b1;
        wait_start();
        chk("tmo_data", i2c_data, 32'h78420011);
        begin
            int n = 0;
            while (start === 1'b1 && n < 300) begin
                tick();
                n++;
            end
            chk("tmo_len", n, TMO);
        end
        chk("tmo_done", {30'b0, req1_done, req0_done}, 32'd2);
        chk("tmo_flag", {30'b0, req1_timeout, req0_timeout}, 32'd2);
        chk("tmo_ack", {30'b0, req1_ack, req0_ack}, 32'd0);
        close_xfer(1'b1);

        // abort: req0 drops mid-transfer, req1 pending
        req0_data  = 32'h78300a0b;
        req1_data  = cfg_word(16'h300c, 8'h0d);
        req0_start = 1'b1;
        req1_start = 1'b1;
        wait_start();
        chk("abort_grant", {30'b0, grant}, 32'd1);
        repeat (5) tick();
        req0_start = 1'b0;
        repeat (3) tick();
        chk("abort_start_held", {31'b0, start}, 32'd1);
        tr_end = 1'b1;
        ack    = 1'b1;
        tick();
        tr_end = 1'b0;
        ack    = 1'b0;
        chk("abort_done", {30'b0, req1_done, req0_done}, 32'd1);
        tick();
        chk("abort_pulse", {31'b0, req0_done}, 32'd0);
        gap_len();
        wait_start();
        chk("pending_grant", {30'b0, grant}, 32'd2);
        chk("pending_data", i2c_data, 32'h78300c0d);
        tr_end = 1'b1;
        tick();
        tr_end = 1'b0;
        close_xfer(1'b1);

        // tr_end on the very cycle the watchdog expires
        req0_data  = 32'h78301234;
        req0_start = 1'b1;
        wait_start();
        repeat (TMO - 1) tick();
        chk("coll_start_held", {31'b0, start}, 32'd1);
        tr_end = 1'b1;
        ack    = 1'b1;
        tick();
        tr_end = 1'b0;
        ack    = 1'b0;
        chk("coll_done", {30'b0, req1_done, req0_done}, 32'd1);
        chk("coll_timeout", {30'b0, req1_timeout, req0_timeout}, 32'd0);
        chk("coll_ack", {30'b0, req1_ack, req0_ack}, 32'd1);
        close_xfer(1'b0);

        // reset in the middle of a transfer owned by requester 0
        req0_data  = 32'h78310301;
        req0_start = 1'b1;
        wait_start();
        chk("pre_rst_grant", {30'b0, grant}, 32'd1);
        repeat (3) tick();
        camera_rst = 1'b1;
        #1;
        chk("arst_start", {31'b0, start}, 32'd0);
        chk("arst_grant", {30'b0, grant}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {30'b0, req1_done, req0_done}, 32'd0);
        chk("arst_data", i2c_data, 32'd0);
        req1_data  = 32'h78310302;
        req1_start = 1'b1;
        tick();
        tick();
        camera_rst = 1'b0;
        wait_start();
        chk("post_rst_tie", {30'b0, grant}, 32'd1);
        chk("post_rst_data", i2c_data, 32'h78310301);
        tr_end = 1'b1;
        tick();
        tr_end = 1'b0;
        chk("post_rst_done", {30'b0, req1_done, req0_done}, 32'd1);
        close_xfer(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
